// File: rtl/raymarch_frame_scheduler_if.sv
// Bus between the frame scheduler, the raymarcher and the framebuffer write port.
// master = scheduler side, slave = raymarcher/framebuffer/control side.
// RGB565_EN narrows the framebuffer data path to 16 bits.
interface raymarch_frame_scheduler_if #(
    parameter int ADDR_W = 16
);
`ifdef RGB565_EN
    localparam int DATA_W = 16;
`else
    localparam int DATA_W = 24;
`endif

    logic              frame_start_in;
    logic [32:0]       rm_x_out;
    logic [32:0]       rm_y_out;
    logic              rm_start_out;
    logic              rm_done_in;
    logic [32:0]       rm_x_in;
    logic [32:0]       rm_y_in;
    logic [7:0]        rm_red_in;
    logic [7:0]        rm_green_in;
    logic [7:0]        rm_blue_in;
    logic              fb_we_out;
    logic [ADDR_W-1:0] fb_addr_out;
    logic [DATA_W-1:0] fb_data_out;
    logic              fb_ready_in;
    logic              busy_out;
    logic              frame_done_out;
    logic              mismatch_out;
    logic [15:0]       timeout_cnt_out;

    modport master (
        input  frame_start_in, rm_done_in, rm_x_in, rm_y_in,
               rm_red_in, rm_green_in, rm_blue_in, fb_ready_in,
        output rm_x_out, rm_y_out, rm_start_out, fb_we_out, fb_addr_out,
               fb_data_out, busy_out, frame_done_out, mismatch_out, timeout_cnt_out
    );

    modport slave (
        output frame_start_in, rm_done_in, rm_x_in, rm_y_in,
               rm_red_in, rm_green_in, rm_blue_in, fb_ready_in,
        input  rm_x_out, rm_y_out, rm_start_out, fb_we_out, fb_addr_out,
               fb_data_out, busy_out, frame_done_out, mismatch_out, timeout_cnt_out
    );
endinterface

// File: rtl/raymarch_frame_scheduler.sv
// Raster-order pixel scheduler: issues coordinates to the raymarcher, waits for
// pixel_done (with a per-pixel timeout), checks returned coordinates and writes
// the colour into the framebuffer. Optional macro RGB565_EN packs pixels as
// {r[7:3], g[7:2], b[7:3]} instead of 24-bit {r, g, b}.
// ADDR_W must match the ADDR_W of the connected interface instance.
module raymarch_frame_scheduler #(
    parameter int          WIDTH      = 320,
    parameter int          HEIGHT     = 180,
    parameter int          ADDR_W     = 16,
    parameter int          TIMEOUT    = 65535,
    parameter logic [23:0] FAULT_RGB  = 24'hFF00FF,
    parameter bit          CONTINUOUS = 1'b0
) (
    input logic                        clk_in,
    input logic                        rst_in,
    raymarch_frame_scheduler_if.master bus
);
`ifdef RGB565_EN
    localparam int DATA_W = 16;
`else
    localparam int DATA_W = 24;
`endif
    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
    localparam logic [TW-1:0] T_EXPIRE = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

    state_t            state;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] addr;
    logic [TW-1:0]     timer;
    logic [DATA_W-1:0] data;
    logic              start_r;
    logic              we_r;
    logic              busy_r;
    logic              done_r;
    logic              mis_r;
    logic [15:0]       to_cnt;

    function automatic logic [DATA_W-1:0] pack(input logic [23:0] rgb);
`ifdef RGB565_EN
        return {rgb[23:19], rgb[15:10], rgb[7:3]};
`else
        return rgb;
`endif
    endfunction

    // Coordinates come straight from the local counters, which only move on a
    // framebuffer accept, so they are stable from ISSUE through WAIT.
    assign bus.rm_x_out        = 33'(x);
    assign bus.rm_y_out        = 33'(y);
    assign bus.rm_start_out    = start_r;
    assign bus.fb_we_out       = we_r;
    assign bus.fb_addr_out     = addr;
    assign bus.fb_data_out     = data;
    assign bus.busy_out        = busy_r;
    assign bus.frame_done_out  = done_r;
    assign bus.mismatch_out    = mis_r;
    assign bus.timeout_cnt_out = to_cnt;

    // Frame FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            addr    <= '0;
            timer   <= '0;
            data    <= '0;
            start_r <= 1'b0;
            we_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            mis_r   <= 1'b0;
            to_cnt  <= '0;
        end else begin
            start_r <= 1'b0;
            done_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.frame_start_in) begin
                        x       <= '0;
                        y       <= '0;
                        addr    <= '0;
                        mis_r   <= 1'b0;
                        to_cnt  <= '0;
                        busy_r  <= 1'b1;
                        start_r <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A done in the expiry cycle wins: real data, no timeout counted.
                    if (bus.rm_done_in) begin
                        data <= pack({bus.rm_red_in, bus.rm_green_in, bus.rm_blue_in});
                        if (bus.rm_x_in != 33'(x) || bus.rm_y_in != 33'(y))
                            mis_r <= 1'b1;
                        we_r  <= 1'b1;
                        state <= WRITE;
                    end else if (timer == T_EXPIRE) begin
                        data <= pack(FAULT_RGB);
                        if (to_cnt != 16'hFFFF)
                            to_cnt <= to_cnt + 16'd1;
                        we_r  <= 1'b1;
                        state <= WRITE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WRITE: begin
                    if (bus.fb_ready_in) begin
                        we_r <= 1'b0;
                        addr <= addr + ADDR_W'(1);
                        if (x == X_LAST) begin
                            x <= '0;
                            if (y == Y_LAST) begin
                                y      <= '0;
                                done_r <= 1'b1;
                                state  <= DONE;
                            end else begin
                                y       <= y + YW'(1);
                                start_r <= 1'b1;
                                state   <= ISSUE;
                            end
                        end else begin
                            x       <= x + XW'(1);
                            start_r <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (CONTINUOUS) begin
                        x       <= '0;
                        y       <= '0;
                        addr    <= '0;
                        mis_r   <= 1'b0;
                        to_cnt  <= '0;
                        start_r <= 1'b1;
                        state   <= ISSUE;
                    end else begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
